bus_mux_reg: RTL
================

# bus_mux_reg

Parametrised, registered successor to the datapath's combinational bus multiplexer. It selects one of NSRC source words onto the shared processor bus by fixed priority, registers the result, and reports which source drove it. It offers a hold-or-zero policy for idle cycles, and it detects multi-driver select conflicts with a sticky flag and a saturating counter. It sits between the register file, immediate and ALU result register (the source side) and every bus consumer (the load side).

## Interface
- WIDTH, 16, bus and source word width in bits (≥1)
- NSRC, 10, number of sources (≥2); slot 0 = immediate, 1 = ALU result r, 2..9 = r0..r7 in the default processor mapping
- CNT_W, 8, width of the conflict counter
- IDW, derived = max(1, clog2(NSRC)), width of src_id (localparam, not overridable)

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- src_data  in  NSRC*WIDTH  packed source words; source i occupies bits [i*WIDTH +: WIDTH]
- src_sel  in  NSRC  select request per source, active-high
- hold_en  in  1  1 = keep the last bus value when no select is asserted; 0 = drive zero
- clear_conflict  in  1  synchronous clear of conflict and conflict_count
- bus  out  WIDTH  registered bus value
- bus_valid  out  1  1 = bus was driven by a source in the previous cycle
- src_id  out  IDW  index of the source that produced the current bus value
- conflict  out  1  sticky: at least one cycle with ≥2 src_sel bits set since the last clear
- conflict_count  out  CNT_W  number of conflict cycles since the last clear, saturating

## Operation
- Priority: the lowest asserted index in src_sel wins (0 highest, NSRC-1 lowest). This is identical to the legacy order immediate > r > r0 > … > r7.
- Winner present: bus <= src_data[win], src_id <= win, bus_valid <= 1.
- No select with hold_en=1: bus and src_id keep their values; bus_valid <= 0.
- No select with hold_en=0: bus <= 0, src_id keeps its value, bus_valid <= 0.
- Data dependence: src_data is sampled every cycle, so a change on the selected source's data is captured even when src_sel is unchanged. This fixes the legacy sensitivity-list defect.
- Conflict detection: a conflict cycle is any cycle with popcount(src_sel) ≥ 2.
  - The priority winner still drives the bus in that cycle.
  - conflict <= 1, and conflict_count increments by 1, saturating at 2^CNT_W-1 with no wrap.
- clear_conflict=1 in a cycle with no conflict: conflict <= 0, conflict_count <= 0.
- clear_conflict=1 in a conflict cycle: the new conflict wins, so conflict <= 1 and conflict_count <= 1.
- Reset (asynchronous, resetn=0): bus=0, bus_valid=0, src_id=0, conflict=0, conflict_count=0. These values are held while resetn=0 and take effect immediately, including mid-transfer.
- Reset release: the first capture happens on the first rising edge with resetn=1.
- Indexing: all selection uses vector indexing over NSRC. There are no per-source named ports.

## Timing
- Latency: exactly 1 cycle from src_sel/src_data at edge N to bus/src_id/bus_valid after edge N.
- Throughput: one transfer per cycle; there are no stall cycles.
- conflict and conflict_count update at the same edge as bus.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Select bits take effect only at clock edges. A select pulse shorter than a cycle and not present at an edge is ignored.

## Test plan
- Reset and idle:
  - Stimulus: hold resetn=0 with src_sel=10'h3FF and all sources driving 16'hFFFF.
  - Response: bus=0, bus_valid=0, src_id=0, conflict=0, conflict_count=0 while resetn=0.
  - After release, at the first edge: bus=16'hFFFF, src_id=0, conflict=1, conflict_count=1.
- Priority sweep:
  - Stimulus: src_data[i]=16'h1000+i; assert one-hot src_sel for i=0..9 on consecutive cycles.
  - Response: one cycle later, bus=16'h1000+i, src_id=i, bus_valid=1, conflict stays 0.
- Data tracking:
  - Stimulus: hold src_sel=10'b0000000100 (r0) and change src_data[2] from 16'h00AA to 16'h0055.
  - Response: bus=16'h0055 on the next cycle.
- Hold vs zero:
  - Stimulus: after bus=16'hBEEF from source 3, drive src_sel=0 with hold_en=1 for 2 cycles, then hold_en=0.
  - Response: bus=16'hBEEF with bus_valid=0 for 2 cycles, then bus=0; src_id stays 3.
- Conflict counting:
  - Stimulus: src_sel=10'b0000110000 for 300 cycles with CNT_W=8.
  - Response: bus=src_data[4], conflict=1, conflict_count saturates at 255.
  - Then clear_conflict=1 with src_sel one-hot: count=0, conflict=0.
  - Then clear_conflict=1 with a conflicting src_sel: count=1, conflict=1.
- Mid-operation reset:
  - Stimulus: assert resetn=0 mid-cycle during streaming transfers with conflict_count=5.
  - Response: all outputs are at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered fixed-priority bus multiplexer.
// Lowest asserted src_sel index wins and drives the bus one cycle later.
// Idle cycles either hold the last bus value or drive zero.
// Multi-driver select cycles set a sticky flag and bump a saturating counter.
module bus_mux_reg #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 10,
  parameter int CNT_W = 8,
  localparam int IDW  = (NSRC > 2) ? $clog2(NSRC) : 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         src_sel,
  input  logic                    hold_en,
  input  logic                    clear_conflict,
  output logic [WIDTH-1:0]        bus,
  output logic                    bus_valid,
  output logic [IDW-1:0]          src_id,
  output logic                    conflict,
  output logic [CNT_W-1:0]        conflict_count
);

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [IDW-1:0]   r_id;
  logic             r_conflict;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [WIDTH-1:0] w_data;
  logic             w_multi;
  logic             w_cnt_sat;

  // Priority encode: scan high to low so the lowest asserted index is kept last.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_data = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_sel[i]) begin
        w_any  = 1'b1;
        w_win  = IDW'(i);
        w_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi   = |(src_sel & (src_sel - 1'b1));
  assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}});

  // Bus datapath: capture the winner, otherwise hold or zero the bus.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bus   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
    end else if (w_any) begin
      r_bus   <= w_data;
      r_valid <= 1'b1;
      r_id    <= w_win;
    end else begin
      r_valid <= 1'b0;
      if (!hold_en) r_bus <= '0;
    end
  end

  // Conflict tracking: a conflict in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else if (w_multi) begin
      r_conflict <= 1'b1;
      if (clear_conflict)  r_cnt <= CNT_W'(1);
      else if (!w_cnt_sat) r_cnt <= r_cnt + 1'b1;
    end else if (clear_conflict) begin
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end
  end

  assign bus            = r_bus;
  assign bus_valid      = r_valid;
  assign src_id         = r_id;
  assign conflict       = r_conflict;
  assign conflict_count = r_cnt;

endmodule
